// File: rtl/simplez_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : simplez_mem_arbiter_if
// Description : Bundles the CPU and host request ports and the RAM-side
//               signals of simplez_mem_arbiter. The host_lock signal exists
//               only when SIMPLEZ_ARB_HOST_LOCK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface simplez_mem_arbiter_if #(
    parameter int AW = 9,
    parameter int DW = 12
);
    logic          cpu_req;
    logic          cpu_rw;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;

    logic          host_req;
    logic          host_rw;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
`ifdef SIMPLEZ_ARB_HOST_LOCK_EN
    logic          host_lock;
`endif

    logic [AW-1:0] mem_addr;
    logic          mem_rw;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic          owner;

    // Arbiter side
    modport slave (
`ifdef SIMPLEZ_ARB_HOST_LOCK_EN
        input  host_lock,
`endif
        input  cpu_req, cpu_rw, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  host_req, host_rw, host_addr, host_wdata,
        output host_ack, host_rdata,
        output mem_addr, mem_rw, mem_din, owner,
        input  mem_dout
    );

    // Requester and RAM side
    modport master (
`ifdef SIMPLEZ_ARB_HOST_LOCK_EN
        output host_lock,
`endif
        output cpu_req, cpu_rw, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output host_req, host_rw, host_addr, host_wdata,
        input  host_ack, host_rdata,
        input  mem_addr, mem_rw, mem_din, owner,
        output mem_dout
    );
endinterface
`default_nettype wire

// File: rtl/simplez_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : simplez_mem_arbiter
// Description : Shares the single-port Simplez RAM between the CPU and a host
//               loader with a CPU-priority, burst-limited arbiter.
//               Optional macro SIMPLEZ_ARB_HOST_LOCK_EN adds host_lock.
// Revision    : 1.0 - initial release
// ============================================================================
module simplez_mem_arbiter #(
    parameter int AW        = 9,
    parameter int DW        = 12,
    parameter int CPU_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    simplez_mem_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACC    = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;
    localparam logic [3:0] BURST_MAX = 4'(CPU_BURST);

    logic [1:0]    state_q,    state_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_rw_q,   mem_rw_d;
    logic [DW-1:0] mem_din_q,  mem_din_d;
    logic          owner_q,    owner_d;
    logic [3:0]    burst_q,    burst_d;

    logic w_lock;
    logic w_grant_host;
    logic w_grant_cpu;

`ifdef SIMPLEZ_ARB_HOST_LOCK_EN
    assign w_lock = bus.host_lock;
`else
    assign w_lock = 1'b0;
`endif

    // Host wins when alone, when locked, or once the CPU has used its burst.
    assign w_grant_host = bus.host_req &&
                          (w_lock || !bus.cpu_req || (burst_q == BURST_MAX));
    assign w_grant_cpu  = bus.cpu_req && !w_lock && !w_grant_host;

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        mem_rw_d   = mem_rw_q;
        mem_din_d  = mem_din_q;
        owner_d    = owner_q;
        burst_d    = burst_q;
        case (state_q)
            ST_IDLE: begin
                if (w_grant_host) begin
                    state_d    = ST_ACC;
                    owner_d    = 1'b1;
                    mem_addr_d = bus.host_addr;
                    mem_rw_d   = bus.host_rw;
                    mem_din_d  = bus.host_wdata;
                    burst_d    = 4'd0;
                end else if (w_grant_cpu) begin
                    state_d    = ST_ACC;
                    owner_d    = 1'b0;
                    mem_addr_d = bus.cpu_addr;
                    mem_rw_d   = bus.cpu_rw;
                    mem_din_d  = bus.cpu_wdata;
                    if (bus.host_req) begin
                        burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + 4'd1;
                    end else begin
                        burst_d = 4'd0;
                    end
                end
            end
            ST_ACC: begin
                // The RAM commits at this edge; return to the safe read level.
                state_d  = ST_RESP;
                mem_rw_d = 1'b1;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                mem_rw_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            mem_addr_q <= '0;
            mem_rw_q   <= 1'b1;
            mem_din_q  <= '0;
            owner_q    <= 1'b0;
            burst_q    <= 4'd0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_rw_q   <= mem_rw_d;
            mem_din_q  <= mem_din_d;
            owner_q    <= owner_d;
            burst_q    <= burst_d;
        end
    end

    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_rw     = mem_rw_q;
    assign bus.mem_din    = mem_din_q;
    assign bus.owner      = owner_q;
    assign bus.cpu_ack    = (state_q == ST_RESP) && !owner_q;
    assign bus.host_ack   = (state_q == ST_RESP) &&  owner_q;
    assign bus.cpu_rdata  = bus.mem_dout;
    assign bus.host_rdata = bus.mem_dout;
endmodule
`default_nettype wire

// File: tb/tb_simplez_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_simplez_mem_arbiter
// Description : Self-checking bench for simplez_mem_arbiter with a RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simplez_mem_arbiter;
    localparam int AW        = 9;
    localparam int DW        = 12;
    localparam int CPU_BURST = 4;
    localparam int DEPTH     = 1 << AW;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    logic [DW-1:0] ram     [0:DEPTH-1];
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    logic          bd_we   = 1'b0;
    logic          bd_fill = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;
    bit            cpu_done;
    bit            host_done;

    simplez_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    simplez_mem_arbiter #(.AW(AW), .DW(DW), .CPU_BURST(CPU_BURST)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM with a backdoor port for preloading.
    always @(posedge clk) begin
        if (bd_fill) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= DW'(i * 37 + 5);
        end else if (bd_we) begin
            ram[bd_addr] <= bd_data;
        end else if (!bus.mem_rw) begin
            ram[bus.mem_addr] <= bus.mem_din;
        end
        bus.mem_dout <= ram[bus.mem_addr];
    end

    task automatic idle_inputs();
        bus.cpu_req    = 1'b0;
        bus.cpu_rw     = 1'b1;
        bus.cpu_addr   = '0;
        bus.cpu_wdata  = '0;
        bus.host_req   = 1'b0;
        bus.host_rw    = 1'b1;
        bus.host_addr  = '0;
        bus.host_wdata = '0;
`ifdef SIMPLEZ_ARB_HOST_LOCK_EN
        bus.host_lock  = 1'b0;
`endif
    endtask

    task automatic apply_reset();
        idle_inputs();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        @(posedge clk); #1;
        bd_we   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.cpu_ack !== 1'b0) begin failures++; $display("FAIL reset_cpu_ack got=%b exp=0", bus.cpu_ack); end
        checks++; if (bus.host_ack !== 1'b0) begin failures++; $display("FAIL reset_host_ack got=%b exp=0", bus.host_ack); end
        checks++; if (bus.mem_rw !== 1'b1) begin failures++; $display("FAIL reset_mem_rw got=%b exp=1", bus.mem_rw); end
        checks++; if (bus.mem_addr !== 9'h000) begin failures++; $display("FAIL reset_mem_addr got=%h exp=000", bus.mem_addr); end
        checks++; if (bus.mem_din !== 12'h000) begin failures++; $display("FAIL reset_mem_din got=%h exp=000", bus.mem_din); end
        checks++; if (bus.owner !== 1'b0) begin failures++; $display("FAIL reset_owner got=%b exp=0", bus.owner); end
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_cpu_read();
        bit hseen = 0;
        bd_write(9'h005, 12'h3A7);
        bus.cpu_rw = 1'b1; bus.cpu_addr = 9'h005; bus.cpu_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.host_ack) hseen = 1;
            if (c < 2) begin
                checks++; if (bus.cpu_ack !== 1'b0) begin failures++; $display("FAIL cpu_read_early_ack cycle=%0d got=%b exp=0", c, bus.cpu_ack); end
            end
        end
        checks++; if (bus.cpu_ack !== 1'b1) begin failures++; $display("FAIL cpu_read_ack got=%b exp=1", bus.cpu_ack); end
        checks++; if (bus.cpu_rdata !== 12'h3A7) begin failures++; $display("FAIL cpu_read_data got=%h exp=3a7", bus.cpu_rdata); end
        checks++; if (hseen !== 1'b0) begin failures++; $display("FAIL cpu_read_host_ack got=%b exp=0", hseen); end
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_host_write_cpu_read();
        logic [2:0] rw0 = '0;
        bus.host_rw = 1'b0; bus.host_addr = 9'h1FF; bus.host_wdata = 12'hFFF; bus.host_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rw0[c] = (bus.mem_rw === 1'b0);
        end
        checks++; if (bus.host_ack !== 1'b1) begin failures++; $display("FAIL host_write_ack got=%b exp=1", bus.host_ack); end
        checks++; if (bus.cpu_ack !== 1'b0) begin failures++; $display("FAIL host_write_cpu_ack got=%b exp=0", bus.cpu_ack); end
        checks++; if (rw0 !== 3'b010) begin failures++; $display("FAIL host_write_rw_window got=%b exp=010", rw0); end
        @(posedge clk); #1;
        bus.host_req = 1'b0;
        checks++; if (ram[9'h1FF] !== 12'hFFF) begin failures++; $display("FAIL host_write_ram got=%h exp=fff", ram[9'h1FF]); end
        bus.cpu_rw = 1'b1; bus.cpu_addr = 9'h1FF; bus.cpu_req = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.cpu_ack !== 1'b1) begin failures++; $display("FAIL cpu_readback_ack got=%b exp=1", bus.cpu_ack); end
        checks++; if (bus.cpu_rdata !== 12'hFFF) begin failures++; $display("FAIL cpu_readback_data got=%h exp=fff", bus.cpu_rdata); end
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_starvation();
        int  got [0:9];
        int  own [0:9];
        int  n = 0;
        int  run = 0;
        int  exp_who;
        apply_reset();
        bus.cpu_rw = 1'b1;  bus.cpu_addr = 9'h011;  bus.cpu_req = 1'b1;
        bus.host_rw = 1'b1; bus.host_addr = 9'h022; bus.host_req = 1'b1;
        for (int c = 0; c < 60 && n < 10; c++) begin
            @(negedge clk);
            if (bus.cpu_ack || bus.host_ack) begin
                got[n] = bus.host_ack ? 1 : 0;
                own[n] = int'(bus.owner);
                n++;
            end
        end
        @(posedge clk); #1;
        bus.cpu_req = 1'b0; bus.host_req = 1'b0;
        checks++; if (n != 10) begin failures++; $display("FAIL starve_ack_count got=%0d exp=10", n); end
        for (int i = 0; i < n; i++) begin
            exp_who = (run == CPU_BURST) ? 1 : 0;
            run     = exp_who ? 0 : run + 1;
            checks++; if (got[i] != exp_who) begin failures++; $display("FAIL starve_order idx=%0d got=%0d exp=%0d", i, got[i], exp_who); end
            checks++; if (own[i] != exp_who) begin failures++; $display("FAIL starve_owner idx=%0d got=%0d exp=%0d", i, own[i], exp_who); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_simultaneous();
        int  c_cpu = -1;
        int  c_host = -1;
        bit  ca, ha;
        apply_reset();
        bus.cpu_rw = 1'b1;  bus.cpu_addr = 9'h033;  bus.cpu_req = 1'b1;
        bus.host_rw = 1'b1; bus.host_addr = 9'h044; bus.host_req = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            ca = bus.cpu_ack; ha = bus.host_ack;
            if (ca && c_cpu < 0) c_cpu = c;
            if (ha && c_host < 0) c_host = c;
            @(posedge clk); #1;
            if (ca) bus.cpu_req = 1'b0;
            if (ha) bus.host_req = 1'b0;
        end
        bus.cpu_req = 1'b0; bus.host_req = 1'b0;
        checks++; if (c_cpu != 2) begin failures++; $display("FAIL simul_cpu_cycle got=%0d exp=2", c_cpu); end
        checks++; if (c_host != 5) begin failures++; $display("FAIL simul_host_cycle got=%0d exp=5", c_host); end
    endtask

    task automatic test_reset_abort();
        int acks = 0;
        bd_write(9'h010, 12'h111);
        bus.cpu_rw = 1'b0; bus.cpu_addr = 9'h010; bus.cpu_wdata = 12'h222; bus.cpu_req = 1'b1;
        @(posedge clk); #2;
        checks++; if (bus.mem_rw !== 1'b0) begin failures++; $display("FAIL abort_acc_rw got=%b exp=0", bus.mem_rw); end
        rstn = 1'b0;
        #1;
        checks++; if (bus.mem_rw !== 1'b1) begin failures++; $display("FAIL abort_mem_rw got=%b exp=1", bus.mem_rw); end
        bus.cpu_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.cpu_ack || bus.host_ack) acks++;
        end
        checks++; if (acks != 0) begin failures++; $display("FAIL abort_acks got=%0d exp=0", acks); end
        checks++; if (ram[9'h010] !== 12'h111) begin failures++; $display("FAIL abort_ram got=%h exp=111", ram[9'h010]); end
        @(posedge clk); #1;
        bus.cpu_rw = 1'b1; bus.cpu_req = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.cpu_ack !== 1'b1) begin failures++; $display("FAIL abort_idle_ack got=%b exp=1", bus.cpu_ack); end
        checks++; if (bus.cpu_rdata !== 12'h111) begin failures++; $display("FAIL abort_idle_data got=%h exp=111", bus.cpu_rdata); end
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        @(posedge clk); #1;
    endtask

`ifdef SIMPLEZ_ARB_HOST_LOCK_EN
    task automatic test_host_lock();
        int  k = 0;
        int  cacks = 0;
        int  lat = -1;
        bit  ha;
        apply_reset();
        bus.host_lock = 1'b1;
        bus.cpu_rw = 1'b1; bus.cpu_addr = 9'h1A0; bus.cpu_req = 1'b1;
        bus.host_rw = 1'b0; bus.host_addr = 9'h000; bus.host_wdata = 12'h000; bus.host_req = 1'b1;
        for (int c = 0; c < 60 && k < 8; c++) begin
            @(negedge clk);
            ha = bus.host_ack;
            if (bus.cpu_ack) cacks++;
            @(posedge clk); #1;
            if (ha) begin
                k++;
                bus.host_addr  = AW'(k);
                bus.host_wdata = DW'(k);
            end
        end
        bus.host_req  = 1'b0;
        bus.host_lock = 1'b0;
        checks++; if (k != 8) begin failures++; $display("FAIL lock_host_acks got=%0d exp=8", k); end
        checks++; if (cacks != 0) begin failures++; $display("FAIL lock_cpu_acks got=%0d exp=0", cacks); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (ram[i] !== DW'(i)) begin failures++; $display("FAIL lock_ram addr=%0d got=%h exp=%h", i, ram[i], DW'(i)); end
        end
        for (int c = 0; c < 6 && lat < 0; c++) begin
            @(negedge clk);
            if (bus.cpu_ack) lat = c;
        end
        checks++; if (lat != 2) begin failures++; $display("FAIL lock_release_latency got=%0d exp=2", lat); end
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        @(posedge clk); #1;
    endtask
`endif

    task automatic rand_driver(input bit is_host, input int ntx);
        bit got;
        for (int t = 0; t < ntx; t++) begin
            int gap = int'($urandom_range(0, 3));
            if (gap > 0) begin
                if (is_host) bus.host_req = 1'b0; else bus.cpu_req = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            if (is_host) begin
                bus.host_rw = 1'($urandom); bus.host_addr = AW'($urandom);
                bus.host_wdata = DW'($urandom); bus.host_req = 1'b1;
            end else begin
                bus.cpu_rw = 1'($urandom); bus.cpu_addr = AW'($urandom);
                bus.cpu_wdata = DW'($urandom); bus.cpu_req = 1'b1;
            end
            got = 0;
            for (int c = 0; c < 40 && !got; c++) begin
                @(negedge clk);
                got = is_host ? bus.host_ack : bus.cpu_ack;
            end
            checks++; if (!got) begin failures++; $display("FAIL rand_timeout host=%0d txn=%0d got=no_ack exp=ack", is_host, t); end
            @(posedge clk); #1;
        end
        if (is_host) begin bus.host_req = 1'b0; host_done = 1; end
        else begin bus.cpu_req = 1'b0; cpu_done = 1; end
    endtask

    task automatic test_random();
        bit            busy = 0;
        bit            who = 0;
        bit            hw;
        bit            m_rw = 1;
        logic [AW-1:0] m_addr = '0;
        logic [DW-1:0] m_wd = '0;
        logic [DW-1:0] rd;
        int            ack_n = 0;
        int            cnt = 0;
        int            n = 0;
        apply_reset();
        bd_fill = 1'b1;
        @(posedge clk); #1;
        bd_fill = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = ram[i];
        cpu_done = 0; host_done = 0;
        fork
            rand_driver(1'b0, 40);
            rand_driver(1'b1, 40);
            begin
                while (!(cpu_done && host_done)) begin
                    @(negedge clk);
                    checks++; if (bus.cpu_ack !== (busy && n == ack_n && !who)) begin failures++; $display("FAIL rand_cpu_ack cyc=%0d got=%b exp=%b", n, bus.cpu_ack, busy && n == ack_n && !who); end
                    checks++; if (bus.host_ack !== (busy && n == ack_n && who)) begin failures++; $display("FAIL rand_host_ack cyc=%0d got=%b exp=%b", n, bus.host_ack, busy && n == ack_n && who); end
                    if (busy && n == ack_n) begin
                        checks++; if (bus.owner !== who) begin failures++; $display("FAIL rand_owner cyc=%0d got=%b exp=%b", n, bus.owner, who); end
                        if (m_rw) begin
                            rd = who ? bus.host_rdata : bus.cpu_rdata;
                            checks++; if (rd !== ref_mem[m_addr]) begin failures++; $display("FAIL rand_rdata addr=%h got=%h exp=%h", m_addr, rd, ref_mem[m_addr]); end
                        end else begin
                            ref_mem[m_addr] = m_wd;
                        end
                        busy = 0;
                    end else if (!busy && (bus.cpu_req || bus.host_req)) begin
                        hw = bus.host_req && (!bus.cpu_req || cnt == CPU_BURST);
                        if (hw) cnt = 0;
                        else if (bus.host_req) cnt = (cnt == CPU_BURST) ? cnt : cnt + 1;
                        else cnt = 0;
                        who    = hw;
                        m_rw   = hw ? bus.host_rw : bus.cpu_rw;
                        m_addr = hw ? bus.host_addr : bus.cpu_addr;
                        m_wd   = hw ? bus.host_wdata : bus.cpu_wdata;
                        busy   = 1;
                        ack_n  = n + 2;
                    end
                    n++;
                end
            end
        join
        for (int i = 0; i < 16; i++) begin
            int a = int'($urandom_range(0, DEPTH - 1));
            checks++; if (ram[a] !== ref_mem[a]) begin failures++; $display("FAIL rand_ram addr=%0d got=%h exp=%h", a, ram[a], ref_mem[a]); end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_cpu_read();
        test_host_write_cpu_read();
        test_starvation();
        test_simultaneous();
        test_reset_abort();
`ifdef SIMPLEZ_ARB_HOST_LOCK_EN
        test_host_lock();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
